// File: rtl/router_pkg.sv
// Shared types and constants for the multi-channel weight router.
package router_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int unsigned FIFO_DEPTH_DEF = 4;
  localparam int unsigned FIFO_PTR_W     = $clog2(FIFO_DEPTH_DEF);

endpackage

// File: rtl/router_wght_fifo.sv
// Synchronous FIFO buffering GLB weight words ahead of the SPAD write port.
module router_wght_fifo #(
  parameter int unsigned DATA_BITWIDTH = 16,
  parameter int unsigned FIFO_DEPTH    = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          push_i,
  input  logic                          pop_i,
  input  logic [DATA_BITWIDTH-1:0]      wdata_i,
  output logic [DATA_BITWIDTH-1:0]      rdata_o,
  output logic                          full_o,
  output logic                          empty_o,
  output logic [$clog2(FIFO_DEPTH):0]   count_o
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);

  logic [DATA_BITWIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0]            wr_ptr_q, rd_ptr_q;
  logic [PW:0]              cnt_q;

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop_i)  rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({push_i, pop_i})
        2'b10:   cnt_q <= cnt_q + (PW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (PW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign full_o  = (cnt_q == (PW+1)'(FIFO_DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;

endmodule

// File: rtl/router_wght_mc.sv
// Multi-channel weight router: bursts GLB words through a FIFO into the
// weight scratchpads of a masked set of PE channels.
module router_wght_mc
  import router_pkg::*;
#(
  parameter int unsigned DATA_BITWIDTH      = 16,
  parameter int unsigned ADDR_BITWIDTH_GLB  = 10,
  parameter int unsigned ADDR_BITWIDTH_SPAD = 9,
  parameter int unsigned NUM_CH             = 4,
  parameter int unsigned FIFO_DEPTH         = FIFO_DEPTH_DEF,
  parameter int unsigned LEN_BITWIDTH       = 9
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [ADDR_BITWIDTH_GLB-1:0]  cfg_base_addr,
  input  logic [LEN_BITWIDTH-1:0]       cfg_len,
  input  logic [NUM_CH-1:0]             cfg_ch_mask,
  input  logic [ADDR_BITWIDTH_SPAD-1:0] cfg_spad_base,
  output logic [ADDR_BITWIDTH_GLB-1:0]  glb_addr,
  output logic                          glb_req,
  input  logic [DATA_BITWIDTH-1:0]      glb_data,
  input  logic                          glb_valid,
  output logic [DATA_BITWIDTH-1:0]      spad_data,
  output logic [ADDR_BITWIDTH_SPAD-1:0] spad_addr,
  output logic [NUM_CH-1:0]             spad_load_en,
  input  logic [NUM_CH-1:0]             spad_ready,
  output logic                          busy,
  output logic                          done
);

  localparam int unsigned PW = (FIFO_DEPTH == FIFO_DEPTH_DEF) ? FIFO_PTR_W : $clog2(FIFO_DEPTH);

  state_t                        state_q, state_d;
  logic                          start_s1_q, start_s2_q;
  logic [ADDR_BITWIDTH_GLB-1:0]  base_q;
  logic [LEN_BITWIDTH-1:0]       len_q;
  logic [NUM_CH-1:0]             mask_q;
  logic [ADDR_BITWIDTH_SPAD-1:0] sbase_q;
  logic [LEN_BITWIDTH-1:0]       issued_q, issued_d, written_q, written_d;
  logic                          glb_req_q;
  logic [ADDR_BITWIDTH_GLB-1:0]  glb_addr_q;
  logic [DATA_BITWIDTH-1:0]      spad_data_q;
  logic [ADDR_BITWIDTH_SPAD-1:0] spad_addr_q;
  logic [NUM_CH-1:0]             spad_load_en_q;
  logic                          busy_q, done_q;

  logic                     start_edge, launch, in_run, push_v, fire, bypass, req_d, credit;
  logic                     fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [DATA_BITWIDTH-1:0] fifo_rdata, pop_word;
  logic [PW:0]              fifo_cnt;
  logic [PW+1:0]            inflight;

  router_wght_fifo #(
    .DATA_BITWIDTH(DATA_BITWIDTH),
    .FIFO_DEPTH   (FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .push_i (fifo_push),
    .pop_i  (fifo_pop),
    .wdata_i(glb_data),
    .rdata_o(fifo_rdata),
    .full_o (fifo_full),
    .empty_o(fifo_empty),
    .count_o(fifo_cnt)
  );

  always_comb begin
    start_edge = start_s1_q & ~start_s2_q;
    launch     = (state_q == IDLE) & start_edge;
    in_run     = (state_q == RUN);
    push_v     = in_run & glb_valid;
    // An arriving word bypasses an empty FIFO so a write lands 2 cycles after its request.
    fire       = in_run & (~fifo_empty | push_v) & (&(spad_ready | ~mask_q));
    bypass     = fifo_empty & push_v & fire;
    fifo_push  = push_v & ~bypass & (~fifo_full | fire);
    fifo_pop   = fire & ~fifo_empty;
    pop_word   = fifo_empty ? glb_data : fifo_rdata;
    // Credit counts buffered words, the word arriving now and the request already on the bus.
    inflight   = (PW+2)'(fifo_cnt) + (PW+2)'(push_v) + (PW+2)'(glb_req_q);
    credit     = inflight < (PW+2)'(FIFO_DEPTH);
    req_d      = in_run & (issued_q < len_q) & credit;
    issued_d   = launch ? '0 : issued_q + LEN_BITWIDTH'(req_d);
    written_d  = launch ? '0 : written_q + LEN_BITWIDTH'(fire);

    state_d = state_q;
    case (state_q)
      IDLE: if (start_edge)
              state_d = ((cfg_len != '0) && (cfg_ch_mask != '0)) ? RUN : DONE;
      RUN:  if (fire && (written_q == len_q - LEN_BITWIDTH'(1))) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      start_s1_q     <= 1'b0;
      start_s2_q     <= 1'b0;
      base_q         <= '0;
      len_q          <= '0;
      mask_q         <= '0;
      sbase_q        <= '0;
      issued_q       <= '0;
      written_q      <= '0;
      glb_req_q      <= 1'b0;
      glb_addr_q     <= '0;
      spad_data_q    <= '0;
      spad_addr_q    <= '0;
      spad_load_en_q <= '0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      state_q    <= state_d;
      start_s1_q <= start;
      start_s2_q <= start_s1_q;
      issued_q   <= issued_d;
      written_q  <= written_d;
      if (launch) begin
        base_q  <= cfg_base_addr;
        len_q   <= cfg_len;
        mask_q  <= cfg_ch_mask;
        sbase_q <= cfg_spad_base;
      end
      glb_req_q <= req_d;
      if (req_d) glb_addr_q <= base_q + ADDR_BITWIDTH_GLB'(issued_q);
      spad_load_en_q <= fire ? mask_q : '0;
      if (fire) begin
        spad_data_q <= pop_word;
        spad_addr_q <= sbase_q + ADDR_BITWIDTH_SPAD'(written_q);
      end
      busy_q <= (state_q != IDLE);
      done_q <= (state_q == DONE);
    end
  end

  assign glb_req      = glb_req_q;
  assign glb_addr     = glb_addr_q;
  assign spad_data    = spad_data_q;
  assign spad_addr    = spad_addr_q;
  assign spad_load_en = spad_load_en_q;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule

// File: tb/tb_router_wght_mc.sv
// Directed bench for router_wght_mc with a GLB responder and write/request monitor.
module tb_router_wght_mc;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [9:0]  cfg_base_addr;
  logic [8:0]  cfg_len;
  logic [3:0]  cfg_ch_mask;
  logic [8:0]  cfg_spad_base;
  logic [9:0]  glb_addr;
  logic        glb_req;
  logic [15:0] glb_data = '0;
  logic        glb_valid = 1'b0;
  logic [15:0] spad_data;
  logic [8:0]  spad_addr;
  logic [3:0]  spad_load_en;
  logic [3:0]  spad_ready;
  logic        busy, done;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [9:0]  req_addr [128];
  int          req_cyc  [128];
  logic [3:0]  w_en     [128];
  logic [8:0]  w_addr   [128];
  logic [15:0] w_data   [128];
  int          w_cyc    [128];
  int          nreq = 0, nw = 0, ndone = 0, done_cyc = 0;
  logic        req_prev = 1'b0;
  logic [9:0]  addr_prev = '0;
  int          r0, w0, d0, p;

  router_wght_mc #(
    .DATA_BITWIDTH(16), .ADDR_BITWIDTH_GLB(10), .ADDR_BITWIDTH_SPAD(9),
    .NUM_CH(4), .FIFO_DEPTH(4), .LEN_BITWIDTH(9)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .cfg_base_addr(cfg_base_addr), .cfg_len(cfg_len),
    .cfg_ch_mask(cfg_ch_mask), .cfg_spad_base(cfg_spad_base),
    .glb_addr(glb_addr), .glb_req(glb_req), .glb_data(glb_data), .glb_valid(glb_valid),
    .spad_data(spad_data), .spad_addr(spad_addr), .spad_load_en(spad_load_en),
    .spad_ready(spad_ready), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // GLB answers each request one cycle later with data = {6'h15, addr}.
  always @(negedge clk) begin
    glb_valid = req_prev;
    glb_data  = {6'h15, addr_prev};
    req_prev  = glb_req;
    addr_prev = glb_addr;
    if (glb_req && nreq < 128) begin
      req_addr[nreq] = glb_addr;
      req_cyc[nreq]  = cyc;
      nreq++;
    end
    if (spad_load_en != '0 && nw < 128) begin
      w_en[nw]   = spad_load_en;
      w_addr[nw] = spad_addr;
      w_data[nw] = spad_data;
      w_cyc[nw]  = cyc;
      nw++;
    end
    if (done) begin
      ndone++;
      done_cyc = cyc;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic launch(input logic [9:0] b, input logic [8:0] l, input logic [3:0] m,
                        input logic [8:0] sb);
    r0 = nreq; w0 = nw; d0 = ndone;
    cfg_base_addr = b; cfg_len = l; cfg_ch_mask = m; cfg_spad_base = sb;
    start = 1'b1;
    p = cyc;
    repeat (3) begin @(posedge clk); #1; end
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 200 && ndone == d0; i++) begin @(posedge clk); #1; end
    repeat (3) begin @(posedge clk); #1; end
    chk({tag, "_ndone"}, 32'(ndone - d0), 32'd1);
    chk({tag, "_busy_end"}, 32'(busy), 32'd0);
  endtask

  task automatic check_burst(input string tag, input logic [9:0] b, input int l,
                             input logic [3:0] m, input logic [8:0] sb);
    logic [9:0]  ea;
    logic [8:0]  es;
    chk({tag, "_nreq"}, 32'(nreq - r0), 32'(l));
    chk({tag, "_nwr"},  32'(nw - w0),   32'(l));
    for (int k = 0; k < l; k++) begin
      ea = b + 10'(k);
      es = sb + 9'(k);
      chk({tag, "_req_addr"}, 32'(req_addr[r0 + k]), 32'(ea));
      chk({tag, "_wr_addr"},  32'(w_addr[w0 + k]),   32'(es));
      chk({tag, "_wr_data"},  32'(w_data[w0 + k]),   32'({6'h15, ea}));
      chk({tag, "_wr_en"},    32'(w_en[w0 + k]),     32'(m));
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0;
    cfg_base_addr = '0; cfg_len = '0; cfg_ch_mask = '0; cfg_spad_base = '0;
    spad_ready = 4'hF;
    repeat (3) begin @(posedge clk); #1; end
    chk("rst_glb_req",   32'(glb_req),      32'd0);
    chk("rst_glb_addr",  32'(glb_addr),     32'd0);
    chk("rst_load_en",   32'(spad_load_en), 32'd0);
    chk("rst_spad_addr", 32'(spad_addr),    32'd0);
    chk("rst_spad_data", 32'(spad_data),    32'd0);
    chk("rst_busy",      32'(busy),         32'd0);
    chk("rst_done",      32'(done),         32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Basic multicast
    launch(10'h010, 9'd4, 4'b0101, 9'h000);
    chk("mc_busy", 32'(busy), 32'd1);
    wait_done("mc");
    check_burst("mc", 10'h010, 4, 4'b0101, 9'h000);
    chk("mc_first_req_cyc", 32'(req_cyc[r0]), 32'(p + 3));
    chk("mc_req_b2b", 32'(req_cyc[r0 + 3] - req_cyc[r0]), 32'd3);
    chk("mc_wr_latency", 32'(w_cyc[w0] - req_cyc[r0]), 32'd2);
    chk("mc_wr_b2b", 32'(w_cyc[w0 + 3] - w_cyc[w0]), 32'd3);
    chk("mc_done_cyc", 32'(done_cyc), 32'(w_cyc[w0 + 3] + 1));

    // Backpressure on channel 2
    launch(10'h100, 9'd8, 4'b1111, 9'h020);
    for (int i = 0; i < 50 && nw == w0; i++) begin @(negedge clk); #1; end
    @(posedge clk); #1;
    spad_ready = 4'b1011;
    repeat (5) begin
      @(posedge clk); #1;
      chk("bp_stall_noload", 32'(spad_load_en), 32'd0);
    end
    chk("bp_req_dropped", 32'(glb_req), 32'd0);
    spad_ready = 4'hF;
    wait_done("bp");
    check_burst("bp", 10'h100, 8, 4'b1111, 9'h020);

    // Address wrap-around
    launch(10'h3FE, 9'd3, 4'b0010, 9'h1FF);
    wait_done("wrap");
    check_burst("wrap", 10'h3FE, 3, 4'b0010, 9'h1FF);

    // Degenerate len=0, then mask=0
    launch(10'h010, 9'd0, 4'b1111, 9'h000);
    wait_done("deg_len");
    chk("deg_len_nreq", 32'(nreq - r0), 32'd0);
    chk("deg_len_nwr", 32'(nw - w0), 32'd0);
    chk("deg_len_done_cyc", 32'(done_cyc), 32'(p + 3));
    launch(10'h010, 9'd4, 4'b0000, 9'h000);
    wait_done("deg_mask");
    chk("deg_mask_nreq", 32'(nreq - r0), 32'd0);
    chk("deg_mask_nwr", 32'(nw - w0), 32'd0);
    chk("deg_mask_done_cyc", 32'(done_cyc), 32'(p + 3));

    // Second start edge during a burst is ignored
    launch(10'h020, 9'd6, 4'b1010, 9'h010);
    @(posedge clk); #1;
    cfg_len = 9'd2; cfg_ch_mask = 4'b0001; start = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    start = 1'b0;
    wait_done("sb");
    check_burst("sb", 10'h020, 6, 4'b1010, 9'h010);

    // Reset after two writes
    launch(10'h040, 9'd6, 4'b0011, 9'h000);
    for (int i = 0; i < 50 && (nw - w0) < 2; i++) begin @(negedge clk); #1; end
    reset = 1'b1;
    @(posedge clk); #1;
    chk("mrst_glb_req", 32'(glb_req),      32'd0);
    chk("mrst_load_en", 32'(spad_load_en), 32'd0);
    chk("mrst_busy",    32'(busy),         32'd0);
    chk("mrst_done",    32'(done),         32'd0);
    chk("mrst_addr",    32'(spad_addr),    32'd0);
    reset = 1'b0;
    repeat (12) begin @(posedge clk); #1; end
    chk("mrst_nwr", 32'(nw - w0), 32'd2);
    chk("mrst_ndone", 32'(ndone - d0), 32'd0);
    launch(10'h050, 9'd3, 4'b1111, 9'h005);
    wait_done("fresh");
    check_burst("fresh", 10'h050, 3, 4'b1111, 9'h005);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
